// File: rtl/lighthouse_pulse_decoder.sv
// Lighthouse pulse decoder: classifies TS4231 envelope pulses as sync/sweep/error and times sweeps.
// Latency: strobes appear 1 cycle after the first inactive synchronized sample (3 cycles after e_in returns idle).
// Backpressure: none; strobes are single-cycle and held fields stay valid until the next event of their kind.
module lighthouse_pulse_decoder #(
  parameter int CLK_FREQ_HZ    = 48_000_000,
  parameter bit ENV_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        e_in,
  output logic        sync_valid,
  output logic        sync_skip,
  output logic        sync_data,
  output logic        sync_axis,
  output logic        sweep_valid,
  output logic        sweep_axis,
  output logic [19:0] sweep_time,
  output logic        pulse_error,
  output logic [15:0] pulse_width,
  output logic        armed
);

  localparam int T_BASE    = CLK_FREQ_HZ / 16000;
  localparam int T_STEP    = CLK_FREQ_HZ / 96000;
  localparam int SWEEP_MAX = CLK_FREQ_HZ / 50000;
  localparam int TIMEOUT   = CLK_FREQ_HZ / 120;
  // Sync code k occupies [SYNC_LO + k*T_STEP, SYNC_LO + (k+1)*T_STEP).
  localparam int SYNC_LO   = T_BASE - T_STEP / 2;
  localparam int SYNC_HI   = SYNC_LO + 8 * T_STEP;

  typedef enum logic [1:0] {DISABLED, WAIT_IDLE, IDLE, PULSE} state_t;

  state_t      state, state_nxt;
  logic        e_meta, e_sync, active;
  logic [15:0] width;
  logic [19:0] cnt;
  logic [19:0] rise_stamp;
  logic        start_pulse, classify;
  logic        is_sweep, is_sync;
  logic [2:0]  code;
  int          width_int, cnt_int;

  assign active    = ENV_ACTIVE_LOW ? ~e_sync : e_sync;
  assign width_int = {16'd0, width};
  assign cnt_int   = {12'd0, cnt};

  // Two-flop synchronizer for the asynchronous envelope input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_meta <= 1'b0;
      e_sync <= 1'b0;
    end else begin
      e_meta <= e_in;
      e_sync <= e_meta;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= DISABLED;
    else       state <= state_nxt;
  end

  // Next state; also flags the pulse start and the classifying sample.
  always_comb begin
    state_nxt   = state;
    start_pulse = 1'b0;
    classify    = 1'b0;
    if (!enable) begin
      state_nxt = DISABLED;
    end else begin
      case (state)
        DISABLED:  state_nxt = WAIT_IDLE;
        WAIT_IDLE: if (!active) state_nxt = IDLE;
        IDLE: begin
          if (active) begin
            state_nxt   = PULSE;
            start_pulse = 1'b1;
          end
        end
        PULSE: begin
          if (!active) begin
            state_nxt = IDLE;
            classify  = 1'b1;
          end
        end
        default: state_nxt = DISABLED;
      endcase
    end
  end

  // Width classification; a saturated width never lands in the sync window.
  always_comb begin
    code     = 3'd0;
    is_sweep = (width_int <= SWEEP_MAX);
    is_sync  = (width_int >= SYNC_LO) && (width_int < SYNC_HI) && (width != 16'hFFFF);
    for (int k = 1; k < 8; k++) begin
      if (width_int >= SYNC_LO + k * T_STEP) code = 3'(k);
    end
  end

  // Width/armed counters, held result fields and single-cycle strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      width       <= '0;
      cnt         <= '0;
      rise_stamp  <= '0;
      armed       <= 1'b0;
      sync_valid  <= 1'b0;
      sync_skip   <= 1'b0;
      sync_data   <= 1'b0;
      sync_axis   <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_axis  <= 1'b0;
      sweep_time  <= '0;
      pulse_error <= 1'b0;
      pulse_width <= '0;
    end else begin
      sync_valid  <= 1'b0;
      sweep_valid <= 1'b0;
      pulse_error <= 1'b0;
      if (!enable) begin
        width      <= '0;
        cnt        <= '0;
        rise_stamp <= '0;
        armed      <= 1'b0;
      end else begin
        if (armed) begin
          cnt <= cnt + 20'd1;
          if (cnt_int + 1 >= TIMEOUT) armed <= 1'b0;
        end
        if (start_pulse) begin
          width      <= 16'd1;
          rise_stamp <= cnt;
        end else if (state == PULSE && active && width != 16'hFFFF) begin
          width <= width + 16'd1;
        end
        if (classify) begin
          pulse_width <= width;
          if (is_sweep) begin
            // Sweeps outside a measurement window are silently dropped.
            if (armed) begin
              sweep_valid <= 1'b1;
              sweep_time  <= rise_stamp;
              armed       <= 1'b0;
            end
          end else if (is_sync) begin
            sync_valid <= 1'b1;
            {sync_skip, sync_data, sync_axis} <= code;
            if (!code[2]) begin
              // The pulse began width+1 clocks before the cycle this value is first seen.
              cnt        <= {4'd0, width} + 20'd1;
              armed      <= 1'b1;
              sweep_axis <= code[0];
            end
          end else begin
            pulse_error <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/lighthouse_pulse_decoder.md
LIGHTHOUSE_PULSE_DECODER -- requirements
Module: lighthouse_pulse_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 48_000_000, system clock frequency used to derive all timing thresholds.
REQ-002 SHALL have parameter ENV_ACTIVE_LOW, default 1; 1 = light pulse present while e_in is low, 0 = while e_in is high.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  decoder run enable, driven by the sensor-configuration done flag.
REQ-006 SHALL have port e_in  input  1  raw TS4231 envelope, asynchronous to clock.
REQ-007 SHALL have port sync_valid  output  1  one-cycle strobe, sync pulse decoded.
REQ-008 SHALL have ports sync_skip, sync_data, sync_axis  output  1 each  decoded bits of the last sync pulse, held until the next sync_valid.
REQ-009 SHALL have port sweep_valid  output  1  one-cycle strobe, sweep hit measured.
REQ-010 SHALL have port sweep_axis  output  1  axis bit of the sync that armed the measurement; held.
REQ-011 SHALL have port sweep_time  output  20  clocks from the arming sync's first active sample to the sweep pulse's first active sample; held.
REQ-012 SHALL have port pulse_error  output  1  one-cycle strobe, pulse width unclassifiable.
REQ-013 SHALL have port pulse_width  output  16  width in clocks of the last completed pulse; held.
REQ-014 SHALL have port armed  output  1  high while a sweep measurement window is open.

Function
REQ-015 SHALL pass e_in through a 2-flop synchronizer and apply ENV_ACTIVE_LOW to form the active level; all measurements SHALL use the synchronized signal only.
REQ-016 SHALL define the derived constants T_BASE = CLK_FREQ_HZ/16000, T_STEP = CLK_FREQ_HZ/96000, SWEEP_MAX = CLK_FREQ_HZ/50000 and TIMEOUT = CLK_FREQ_HZ/120, all integer-truncated (48 MHz: 3000, 500, 960, 400000).
REQ-017 SHALL implement states DISABLED, WAIT_IDLE, IDLE and PULSE.
REQ-018 SHALL force DISABLED whenever enable=0, from any state, clearing counters, armed and all strobes.
REQ-019 SHALL leave DISABLED for WAIT_IDLE when enable=1; WAIT_IDLE SHALL go to IDLE on the first inactive sample, so a pulse in progress at enable is ignored.
REQ-020 SHALL go from IDLE to PULSE on the first active sample, loading width=1 and capturing rise_stamp = the current armed counter value.
REQ-021 SHALL, in PULSE, increment width (saturating at 65535) on each active sample, and classify on the first inactive sample before returning to IDLE.
REQ-022 SHALL classify width <= SWEEP_MAX as a sweep.
REQ-023 SHALL classify as sync with code k (0..7) when T_BASE - T_STEP/2 + k*T_STEP <= width < T_BASE - T_STEP/2 + (k+1)*T_STEP, where code = {skip, data, axis}.
REQ-024 SHALL treat any other width, including saturation, as an error.
REQ-025 SHALL assert all strobes exactly one cycle, on the cycle after the classifying inactive sample; pulse_width SHALL update on the same cycle for every class.
REQ-026 SHALL, on a non-skip sync, load the armed counter with the clocks elapsed since that pulse's first active sample, set armed=1 and latch sweep_axis=axis.
REQ-027 SHALL update the sync_* bits on a skip sync but leave the armed counter and armed untouched.
REQ-028 SHALL increment the armed counter every cycle while armed, setting armed=0 when it reaches TIMEOUT.
REQ-029 SHALL, on a sweep while armed, assert sweep_valid with sweep_time=rise_stamp and then clear armed; a sweep while unarmed SHALL produce no strobe and no error.
REQ-030 SHALL, if enable falls during PULSE, abort the pulse without any strobe.

Reset
REQ-031 SHALL, while reset is asserted, immediately put the state in DISABLED and set all outputs, counters and synchronizer flops to 0.

Verification (CLK_FREQ_HZ=48e6, ENV_ACTIVE_LOW=1)
REQ-032 SHALL check: enable=1, e_in low for 3000 clk -> sync_valid one cycle, skip/data/axis=0/0/0, pulse_width=3000, armed=1.
REQ-033 SHALL check: sync of 3500 clk, then a 480-clk sweep whose first active sample is 96000 clk after the sync's first -> sweep_valid, sweep_time=96000, sweep_axis=1, armed=0.
REQ-034 SHALL check boundaries: width 2750 -> code 0; 2749 -> pulse_error; 960 -> sweep; 961 -> pulse_error; 6749 -> code 7; 6750 -> pulse_error.
REQ-035 SHALL check: non-skip sync, then a 5500-clk skip sync (code 5), then a sweep -> sweep_time measured from the first sync and sync_skip=1.
REQ-036 SHALL check: armed with no sweep for 400000 clk -> armed=0 and a later sweep gives no sweep_valid.
REQ-037 SHALL check: enable=0 mid-pulse, then reset mid-pulse -> no strobes, and all outputs 0.
